// File: rtl/dist_pkg.sv
// Shared sizing and state encoding for the distribution-register load path.
package dist_pkg;

    localparam int DIST_WORDS  = 8;
    localparam int DIST_WORD_W = 32;
    localparam int DIST_W      = DIST_WORDS * DIST_WORD_W;
    localparam int DIST_REG_AW = 5;
    localparam int DIST_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } dist_ld_state_t;

endpackage

// File: rtl/dist_word_assembler.sv
// Counter-indexed capture register: builds one distribution value word by word.
// Word i lands in bits [WORD_W*i +: WORD_W]; the whole value clears when a load starts.
module dist_word_assembler
    import dist_pkg::*;
#(
    parameter int WORDS  = DIST_WORDS,
    parameter int WORD_W = DIST_WORD_W,
    parameter int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    capture,
    input  logic [CNT_W-1:0]        idx,
    input  logic [WORD_W-1:0]       word,
    output logic [WORDS*WORD_W-1:0] data
);

    logic [WORDS-1:0][WORD_W-1:0] words;

    assign data = words;

    for (genvar i = 0; i < WORDS; i++) begin : gWord
        // Each slot only loads when the counter points at it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                words[i] <= '0;
            else if (clear)
                words[i] <= '0;
            else if (capture && (idx == CNT_W'(i)))
                words[i] <= word;
        end
    end

endmodule

// File: rtl/dist_reg_loader.sv
// Fetches one distribution (WORDS consecutive memory words) and commits it to the
// distribution register file as a single-cycle write. One read outstanding at a time.
module dist_reg_loader
    import dist_pkg::*;
#(
    parameter int WORDS  = DIST_WORDS,
    parameter int WORD_W = DIST_WORD_W,
    parameter int ADDR_W = DIST_ADDR_W,
    parameter int REG_AW = DIST_REG_AW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [REG_AW-1:0]       dest_reg,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_valid,
    input  logic [WORD_W-1:0]       mem_rdata,
    output logic                    DRegWrite,
    output logic [REG_AW-1:0]       wrAddr,
    output logic [WORDS*WORD_W-1:0] wrData
);

    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    dist_ld_state_t    state, stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [REG_AW-1:0] destReg;
    logic              accept, capture, lastWord;

    assign accept   = (state == ST_IDLE) && start;
    assign capture  = (state == ST_WAIT) && mem_valid;
    assign lastWord = (cnt == CNT_W'(WORDS - 1));

    // State register; reset aborts any load in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= stateNext;
    end

    // Next state: one request per word, wait for its data, commit after the last.
    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE:   if (start) stateNext = ST_REQ;
            ST_REQ:    stateNext = ST_WAIT;
            ST_WAIT:   if (mem_valid) stateNext = lastWord ? ST_COMMIT : ST_REQ;
            ST_COMMIT: stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state, plus address/counter tracking.
    // mem_addr steps by 4 per word and wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            DRegWrite <= 1'b0;
            mem_addr  <= '0;
            wrAddr    <= '0;
            destReg   <= '0;
            cnt       <= '0;
        end else begin
            busy      <= (stateNext != ST_IDLE);
            mem_rd    <= (stateNext == ST_REQ);
            done      <= (stateNext == ST_COMMIT);
            DRegWrite <= (stateNext == ST_COMMIT);
            if (accept) begin
                mem_addr <= base_addr;
                destReg  <= dest_reg;
                cnt      <= '0;
            end else if (capture && !lastWord) begin
                mem_addr <= mem_addr + ADDR_W'(4);
                cnt      <= cnt + CNT_W'(1);
            end
            if (stateNext == ST_COMMIT)
                wrAddr <= destReg;
        end
    end

    dist_word_assembler #(
        .WORDS  (WORDS),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) uAsm (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .capture (capture),
        .idx     (cnt),
        .word    (mem_rdata),
        .data    (wrData)
    );

endmodule
